ex_pipe_reg_p: RTL and testbench

//  Parametrised EX/MEM pipeline register: latches the EX-stage result and the control fields forwarded from ID.

---
 rtl/ex_pipe_reg_p_if.sv | 59 +++++
 rtl/ex_pipe_reg_p.sv | 161 ++++++++++++++++
 tb/tb_ex_pipe_reg_p.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ex_pipe_reg_p_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_pipe_reg_p_if
// Brief    : ID/EX inputs and EX/MEM outputs of the EX/MEM pipeline register
// Revision : 1.0 - initial release
// ============================================================================
interface ex_pipe_reg_p_if #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int REG_A_W   = 5,
  parameter int MEM_OP_W  = 2,
  parameter int CTRL_OP_W = 2,
  parameter int EXP_W     = 3,
  parameter int NUM_EXP   = 2,
  parameter int CNT_W     = 16
) ();
  logic                 Stall;
  logic                 Flush;
  logic                 IntDetect;
  logic [NUM_EXP-1:0]   ExpReq;
  logic                 StallCntClr;
  logic [DATA_W-1:0]    ALUOut;
  logic [ADDR_W-1:0]    IDPC;
  logic                 IDEn;
  logic                 IDBrFlag;
  logic [MEM_OP_W-1:0]  IDMemOp;
  logic [DATA_W-1:0]    IDMemWrData;
  logic [CTRL_OP_W-1:0] IDCtrlOp;
  logic [REG_A_W-1:0]   IDDstAddr;
  logic                 IDGPRWE_;
  logic [EXP_W-1:0]     IDExpCode;
  logic [ADDR_W-1:0]    EXPC;
  logic                 EXEn;
  logic                 EXBrFlag;
  logic [MEM_OP_W-1:0]  EXMemOp;
  logic [DATA_W-1:0]    EXMemWrData;
  logic [CTRL_OP_W-1:0] EXCtrlOp;
  logic [REG_A_W-1:0]   EXDstAddr;
  logic                 EXGPRWE_;
  logic [EXP_W-1:0]     EXExpCode;
  logic [DATA_W-1:0]    EXOut;
  logic                 ExcPending;
  logic [CNT_W-1:0]     StallCnt;

  modport master (
    output Stall, Flush, IntDetect, ExpReq, StallCntClr, ALUOut,
           IDPC, IDEn, IDBrFlag, IDMemOp, IDMemWrData, IDCtrlOp, IDDstAddr, IDGPRWE_, IDExpCode,
    input  EXPC, EXEn, EXBrFlag, EXMemOp, EXMemWrData, EXCtrlOp, EXDstAddr, EXGPRWE_, EXExpCode,
           EXOut, ExcPending, StallCnt
  );

  modport slave (
    input  Stall, Flush, IntDetect, ExpReq, StallCntClr, ALUOut,
           IDPC, IDEn, IDBrFlag, IDMemOp, IDMemWrData, IDCtrlOp, IDDstAddr, IDGPRWE_, IDExpCode,
    output EXPC, EXEn, EXBrFlag, EXMemOp, EXMemWrData, EXCtrlOp, EXDstAddr, EXGPRWE_, EXExpCode,
           EXOut, ExcPending, StallCnt
  );
endinterface
`default_nettype wire

// File: rtl/ex_pipe_reg_p.sv
`default_nettype none
// ============================================================================
// Module   : ex_pipe_reg_p
// Brief    : EX/MEM pipeline register with stall/flush, exception injection,
//            exception-hold bubbles and a saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module ex_pipe_reg_p #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int REG_A_W   = 5,
  parameter int MEM_OP_W  = 2,
  parameter int CTRL_OP_W = 2,
  parameter int EXP_W     = 3,
  parameter int NUM_EXP   = 2,
  parameter int CNT_W     = 16
) (
  input  wire               clk,
  input  wire               reset_,
  ex_pipe_reg_p_if.slave    bus
);

  generate
    if (NUM_EXP + 1 > (2 ** EXP_W) - 1) begin : g_bad_exp_w
      $fatal(1, "ex_pipe_reg_p: EXP_W too narrow for NUM_EXP sources");
    end
  endgenerate

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ADDR_W-1:0]    r_pc,    w_pc;
  logic                 r_en,    w_en;
  logic                 r_br,    w_br;
  logic [MEM_OP_W-1:0]  r_mop,   w_mop;
  logic [DATA_W-1:0]    r_wd,    w_wd;
  logic [CTRL_OP_W-1:0] r_cop,   w_cop;
  logic [REG_A_W-1:0]   r_dst,   w_dst;
  logic                 r_we_,   w_we_;
  logic [EXP_W-1:0]     r_ec,    w_ec;
  logic [DATA_W-1:0]    r_out,   w_out;
  logic [CNT_W-1:0]     r_cnt;
  logic [EXP_W-1:0]     w_enc;

  // Lowest set request index wins; loop runs high-to-low so it is assigned last.
  always_comb begin
    w_enc = '0;
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (bus.ExpReq[i]) w_enc = EXP_W'(i + 2);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc  = '0;
    w_en  = 1'b0;
    w_br  = 1'b0;
    w_mop = '0;
    w_wd  = '0;
    w_cop = '0;
    w_dst = '0;
    w_we_ = 1'b1;
    w_ec  = '0;
    w_out = '0;
    if (bus.Stall) begin
      w_pc  = r_pc;
      w_en  = r_en;
      w_br  = r_br;
      w_mop = r_mop;
      w_wd  = r_wd;
      w_cop = r_cop;
      w_dst = r_dst;
      w_we_ = r_we_;
      w_ec  = r_ec;
      w_out = r_out;
    end else if (bus.Flush) begin
      w_state_nxt = RUN;
    end else if (r_state == EXC_HOLD) begin
      w_state_nxt = EXC_HOLD;
    end else if (bus.IntDetect || (|bus.ExpReq)) begin
      // Inject: keep the faulting PC for the handler, kill every side effect.
      w_pc        = bus.IDPC;
      w_en        = bus.IDEn;
      w_br        = bus.IDBrFlag;
      w_ec        = bus.IntDetect ? EXP_W'(1) : w_enc;
      w_state_nxt = EXC_HOLD;
    end else begin
      w_pc  = bus.IDPC;
      w_en  = bus.IDEn;
      w_br  = bus.IDBrFlag;
      w_mop = bus.IDMemOp;
      w_wd  = bus.IDMemWrData;
      w_cop = bus.IDCtrlOp;
      w_dst = bus.IDDstAddr;
      w_we_ = bus.IDGPRWE_;
      w_ec  = bus.IDExpCode;
      w_out = bus.ALUOut;
      if (bus.IDExpCode != '0) w_state_nxt = EXC_HOLD;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_en    <= 1'b0;
      r_br    <= 1'b0;
      r_mop   <= '0;
      r_wd    <= '0;
      r_cop   <= '0;
      r_dst   <= '0;
      r_we_   <= 1'b1;
      r_ec    <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc;
      r_en    <= w_en;
      r_br    <= w_br;
      r_mop   <= w_mop;
      r_wd    <= w_wd;
      r_cop   <= w_cop;
      r_dst   <= w_dst;
      r_we_   <= w_we_;
      r_ec    <= w_ec;
      r_out   <= w_out;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
    end else if (bus.StallCntClr) begin
      r_cnt <= '0;
    end else if (bus.Stall && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.EXPC        = r_pc;
  assign bus.EXEn        = r_en;
  assign bus.EXBrFlag    = r_br;
  assign bus.EXMemOp     = r_mop;
  assign bus.EXMemWrData = r_wd;
  assign bus.EXCtrlOp    = r_cop;
  assign bus.EXDstAddr   = r_dst;
  assign bus.EXGPRWE_    = r_we_;
  assign bus.EXExpCode   = r_ec;
  assign bus.EXOut       = r_out;
  assign bus.ExcPending  = (r_state == EXC_HOLD);
  assign bus.StallCnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_pipe_reg_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_pipe_reg_p
// Brief    : Directed vector bench for ex_pipe_reg_p
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_pipe_reg_p;

  typedef struct packed {
    logic        st;
    logic        fl;
    logic        it;
    logic [1:0]  er;
    logic        cc;
    logic [31:0] alu;
    logic [29:0] pc;
    logic        en;
    logic        br;
    logic [1:0]  mop;
    logic [31:0] wd;
    logic [1:0]  cop;
    logic [4:0]  dst;
    logic        we;
    logic [2:0]  ec;
  } in_t;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br;
    logic [1:0]  mop;
    logic [31:0] wd;
    logic [1:0]  cop;
    logic [4:0]  dst;
    logic        we;
    logic [2:0]  ec;
    logic [31:0] out;
    logic        pend;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic reset_ = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  ex_pipe_reg_p_if bus ();
  ex_pipe_reg_p_if #(.CNT_W(4)) bus2 ();

  ex_pipe_reg_p u_dut (.clk(clk), .reset_(reset_), .bus(bus));
  ex_pipe_reg_p #(.CNT_W(4)) u_dut4 (.clk(clk), .reset_(reset_), .bus(bus2));

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, k, got, exp);
    end
  endtask

  task automatic drive(input in_t v);
    bus.Stall       = v.st;
    bus.Flush       = v.fl;
    bus.IntDetect   = v.it;
    bus.ExpReq      = v.er;
    bus.StallCntClr = v.cc;
    bus.ALUOut      = v.alu;
    bus.IDPC        = v.pc;
    bus.IDEn        = v.en;
    bus.IDBrFlag    = v.br;
    bus.IDMemOp     = v.mop;
    bus.IDMemWrData = v.wd;
    bus.IDCtrlOp    = v.cop;
    bus.IDDstAddr   = v.dst;
    bus.IDGPRWE_    = v.we;
    bus.IDExpCode   = v.ec;
  endtask

  task automatic check_out(input int k, input out_t e);
    chk("EXPC", k, 64'(bus.EXPC), 64'(e.pc));
    chk("EXEn", k, 64'(bus.EXEn), 64'(e.en));
    chk("EXBrFlag", k, 64'(bus.EXBrFlag), 64'(e.br));
    chk("EXMemOp", k, 64'(bus.EXMemOp), 64'(e.mop));
    chk("EXMemWrData", k, 64'(bus.EXMemWrData), 64'(e.wd));
    chk("EXCtrlOp", k, 64'(bus.EXCtrlOp), 64'(e.cop));
    chk("EXDstAddr", k, 64'(bus.EXDstAddr), 64'(e.dst));
    chk("EXGPRWE_", k, 64'(bus.EXGPRWE_), 64'(e.we));
    chk("EXExpCode", k, 64'(bus.EXExpCode), 64'(e.ec));
    chk("EXOut", k, 64'(bus.EXOut), 64'(e.out));
    chk("ExcPending", k, 64'(bus.ExcPending), 64'(e.pend));
    chk("StallCnt", k, 64'(bus.StallCnt), 64'(e.cnt));
  endtask

  function automatic out_t bub(input logic p, input logic [15:0] c);
    bub = '{30'h0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0, p, c};
  endfunction

  // A valid, exception-free instruction with selectable control inputs.
  function automatic in_t idv(input logic st, input logic fl, input logic it,
                              input logic [1:0] er, input logic cc);
    idv = '{st, fl, it, er, cc, 32'h1, 30'h44, 1'b1, 1'b0, 2'd1, 32'h33, 2'd1, 5'd6, 1'b0, 3'd0};
  endfunction

  task automatic add(input in_t i, input out_t o);
    tv.push_back('{i, o});
  endtask

  initial begin
    out_t o1, o12, o20;

    o1 = '{30'h3FFFFFFF, 1'b1, 1'b1, 2'd3, 32'hA5A5A5A5, 2'd3, 5'd31, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b0, 16'd0};
    add('{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd5, 30'h100, 1'b1, 1'b0, 2'd2, 32'h11, 2'd1, 5'd3, 1'b0, 3'd0},
        '{30'h100, 1'b1, 1'b0, 2'd2, 32'h11, 2'd1, 5'd3, 1'b0, 3'd0, 32'd5, 1'b0, 16'd0});
    add('{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 30'h3FFFFFFF, 1'b1, 1'b1, 2'd3, 32'hA5A5A5A5, 2'd3, 5'd31, 1'b0, 3'd0}, o1);
    o1.cnt = 16'd1; add(idv(1'b1, 1'b0, 1'b0, 2'b00, 1'b0), o1);
    o1.cnt = 16'd2; add(idv(1'b1, 1'b0, 1'b1, 2'b11, 1'b0), o1);
    o1.cnt = 16'd3; add(idv(1'b1, 1'b0, 1'b0, 2'b00, 1'b0), o1);
    o1.cnt = 16'd0; add(idv(1'b1, 1'b0, 1'b0, 2'b00, 1'b1), o1);
    add('{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'd9, 30'h40, 1'b1, 1'b1, 2'd2, 32'h77, 2'd2, 5'd7, 1'b0, 3'd0},
        '{30'h40, 1'b1, 1'b1, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd2, 32'h0, 1'b1, 16'd0});
    add(idv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0), bub(1'b1, 16'd0));
    add(idv(1'b0, 1'b0, 1'b1, 2'b01, 1'b0), bub(1'b1, 16'd0));
    add(idv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0), bub(1'b1, 16'd0));
    add(idv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0), bub(1'b1, 16'd1));
    add(idv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0), bub(1'b0, 16'd1));
    o12 = '{30'h80, 1'b1, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd1, 32'h0, 1'b1, 16'd1};
    add('{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd3, 30'h80, 1'b1, 1'b0, 2'd1, 32'd5, 2'd1, 5'd2, 1'b0, 3'd0}, o12);
    o12.cnt = 16'd2; add(idv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0), o12);
    add(idv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0), bub(1'b0, 16'd2));
    add('{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd4, 30'h84, 1'b1, 1'b0, 2'd1, 32'd6, 2'd1, 5'd1, 1'b0, 3'd0},
        '{30'h84, 1'b1, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd3, 32'h0, 1'b1, 16'd2});
    add(idv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0), bub(1'b0, 16'd2));
    add('{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd8, 30'h90, 1'b1, 1'b0, 2'd1, 32'h22, 2'd1, 5'd4, 1'b0, 3'd5},
        '{30'h90, 1'b1, 1'b0, 2'd1, 32'h22, 2'd1, 5'd4, 1'b0, 3'd5, 32'd8, 1'b1, 16'd2});
    add(idv(1'b0, 1'b1, 1'b0, 2'b01, 1'b0), bub(1'b0, 16'd2));
    add('{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h12, 30'h10, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd0},
        '{30'h10, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h12, 1'b0, 16'd2});
    o20 = '{30'h1234, 1'b1, 1'b1, 2'd1, 32'hCAFE, 2'd2, 5'd9, 1'b0, 3'd6, 32'hDEADBEEF, 1'b1, 16'd2};
    add('{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF, 30'h1234, 1'b1, 1'b1, 2'd1, 32'hCAFE, 2'd2, 5'd9, 1'b0, 3'd6}, o20);
    o20.cnt = 16'd3; add(idv(1'b1, 1'b0, 1'b0, 2'b00, 1'b0), o20);

    drive(idv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    bus2.Stall = 1'b0; bus2.Flush = 1'b0; bus2.IntDetect = 1'b0; bus2.ExpReq = '0;
    bus2.StallCntClr = 1'b0; bus2.ALUOut = '0; bus2.IDPC = '0; bus2.IDEn = 1'b0;
    bus2.IDBrFlag = 1'b0; bus2.IDMemOp = '0; bus2.IDMemWrData = '0; bus2.IDCtrlOp = '0;
    bus2.IDDstAddr = '0; bus2.IDGPRWE_ = 1'b1; bus2.IDExpCode = '0;

    #1 reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out(-1, bub(1'b0, 16'd0));
    reset_ = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      drive(tv[k].i);
      @(posedge clk);
      #1;
      check_out(k, tv[k].o);
    end

    // Asynchronous reset mid-cycle while holding DEADBEEF in EXC_HOLD.
    #2 reset_ = 1'b0;
    #1;
    check_out(100, bub(1'b0, 16'd0));
    @(posedge clk);
    #1 reset_ = 1'b1;
    drive(idv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0));

    bus2.Stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk("StallCnt4", k, 64'(bus2.StallCnt), (k > 15) ? 64'd15 : 64'(k));
    end
    bus2.StallCntClr = 1'b1;
    @(posedge clk);
    #1;
    chk("StallCnt4Clr", 21, 64'(bus2.StallCnt), 64'd0);
    bus2.Stall = 1'b0;
    bus2.StallCntClr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
